// File: rtl/wb_regfile.sv
// Register file and writeback scoreboard feeding ds/dt operands to execute.
// Optional RF_BYPASS_EN forwards same-cycle writeback data and pend status.
module wb_regfile #(
    parameter int NREG = 64,
    parameter int AW   = 6,
    parameter int DW   = 32,
    parameter int CW   = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_val,
    output logic [DW-1:0] rt_val,
    output logic          rs_pend,
    output logic          rt_pend,
    input  logic          iss_vld,
    input  logic [AW-1:0] iss_dd,
    output logic          iss_rdy,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_dd_val,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dd_val,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_dd_val,
    output logic          wb_err
);

    localparam int CNW = CW + 2;
    localparam logic [CW-1:0] CMAX = '1;

    logic [DW-1:0] rf      [NREG];
    logic [CW-1:0] cnt     [NREG];
    logic [CW-1:0] cnt_nxt [NREG];
    logic          err_set;

    function automatic logic [1:0] ndec(
        input logic [AW-1:0] r,
        input logic [AW-1:0] a,
        input logic [AW-1:0] m,
        input logic [AW-1:0] i
    );
        ndec = {1'b0, a == r} + {1'b0, m == r} + {1'b0, i == r};
    endfunction

    assign iss_rdy = (iss_dd == '0) | (cnt[iss_dd] != CMAX);

    always_comb begin
        logic [CNW-1:0] up;
        logic [CNW-1:0] dn;
        up      = '0;
        dn      = '0;
        err_set = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            up = {2'b00, cnt[r]}
               + CNW'(iss_vld && iss_rdy && (iss_dd == AW'(r)));
            dn = CNW'(ndec(AW'(r), alu_addr, mem_addr, io_addr));
            if (r == 0) begin
                cnt_nxt[r] = '0;
            end else if (dn > up) begin
                cnt_nxt[r] = '0;
                err_set    = 1'b1;
            end else begin
                cnt_nxt[r] = CW'(up - dn);
            end
        end
    end

    // Later assignments win, giving ALU > MEM > IO on address collisions.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) begin
                rf[r]  <= '0;
                cnt[r] <= '0;
            end
            wb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nxt[r];
            if (io_addr != '0)
                rf[io_addr] <= io_dd_val;
            if (mem_addr != '0)
                rf[mem_addr] <= mem_dd_val;
            if (alu_addr != '0)
                rf[alu_addr] <= alu_dd_val;
            if (err_set)
                wb_err <= 1'b1;
        end
    end

    logic [AW-1:0] ra [2];
    logic [DW-1:0] rv [2];
    logic          rp [2];

    assign ra[0] = rs_addr;
    assign ra[1] = rt_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rv[p] = (ra[p] == '0) ? '0 : rf[ra[p]];
            rp[p] = (ra[p] != '0) && (cnt[ra[p]] != '0);
`ifdef RF_BYPASS_EN
            if (ra[p] != '0) begin
                if (io_addr == ra[p])
                    rv[p] = io_dd_val;
                if (mem_addr == ra[p])
                    rv[p] = mem_dd_val;
                if (alu_addr == ra[p])
                    rv[p] = alu_dd_val;
                rp[p] = {2'b00, cnt[ra[p]]}
                      > CNW'(ndec(ra[p], alu_addr, mem_addr, io_addr));
            end
`endif
        end
    end

    assign rs_val  = rv[0];
    assign rt_val  = rv[1];
    assign rs_pend = rp[0];
    assign rt_pend = rp[1];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table plus random
// traffic against a behavioural scoreboard model.
module tb_wb_regfile;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  rs_addr, rt_addr, iss_dd, alu_addr, mem_addr, io_addr;
    logic [31:0] rs_val, rt_val, alu_dd_val, mem_dd_val, io_dd_val;
    logic        rs_pend, rt_pend, iss_vld, iss_rdy, wb_err;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rstn(rstn),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_val(rs_val), .rt_val(rt_val),
        .rs_pend(rs_pend), .rt_pend(rt_pend),
        .iss_vld(iss_vld), .iss_dd(iss_dd), .iss_rdy(iss_rdy),
        .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
        .mem_addr(mem_addr), .mem_dd_val(mem_dd_val),
        .io_addr(io_addr), .io_dd_val(io_dd_val),
        .wb_err(wb_err)
    );

    int checks = 0;
    int errors = 0;

    int  mdat [64];
    int  mcnt [64];
    bit  merr;
    bit  mvalid = 1'b0;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, got, exp, $time);
        end
    endtask

    function automatic int nwb(input int a);
        return int'(alu_addr == 6'(a)) + int'(mem_addr == 6'(a))
             + int'(io_addr == 6'(a));
    endfunction

    function automatic int exp_val(input int a);
        int v;
        if (a == 0) return 0;
        v = mdat[a];
        if (BYP) begin
            if (io_addr == 6'(a))  v = io_dd_val;
            if (mem_addr == 6'(a)) v = mem_dd_val;
            if (alu_addr == 6'(a)) v = alu_dd_val;
        end
        return v;
    endfunction

    function automatic bit exp_pend(input int a);
        if (a == 0) return 1'b0;
        return BYP ? (mcnt[a] > nwb(a)) : (mcnt[a] != 0);
    endfunction

    function automatic bit exp_rdy();
        return (iss_dd == 6'd0) || (mcnt[iss_dd] != 3);
    endfunction

    task automatic drive(input bit r, input int rs, input int rt,
                         input bit iv, input int dd,
                         input int aa, input int av, input int ma,
                         input int mv, input int ia, input int iov);
        @(negedge clk);
        rstn = r; rs_addr = 6'(rs); rt_addr = 6'(rt);
        iss_vld = iv; iss_dd = 6'(dd);
        alu_addr = 6'(aa); alu_dd_val = 32'(av);
        mem_addr = 6'(ma); mem_dd_val = 32'(mv);
        io_addr = 6'(ia); io_dd_val = 32'(iov);
        #1;
        if (mvalid) begin
            chk("m_rs_val", rs_val, exp_val(rs));
            chk("m_rt_val", rt_val, exp_val(rt));
            chk("m_rs_pend", {31'd0, rs_pend}, {31'd0, exp_pend(rs)});
            chk("m_rt_pend", {31'd0, rt_pend}, {31'd0, exp_pend(rt)});
            chk("m_iss_rdy", {31'd0, iss_rdy}, {31'd0, exp_rdy()});
            chk("m_wb_err", {31'd0, wb_err}, {31'd0, merr});
        end
    endtask

    // Scoreboard update: each register's count rises on an accepted issue
    // and falls by one per matching writeback, clamping to 0 with an error.
    task automatic commit();
        bit acc;
        acc = iss_vld && exp_rdy();
        @(posedge clk);
        if (!rstn) begin
            foreach (mdat[i]) begin mdat[i] = 0; mcnt[i] = 0; end
            merr = 1'b0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            for (int r = 1; r < 64; r++) begin
                int tot;
                tot = mcnt[r] + int'(acc && iss_dd == 6'(r));
                if (nwb(r) > tot) begin
                    mcnt[r] = 0;
                    merr = 1'b1;
                end else begin
                    mcnt[r] = tot - nwb(r);
                end
            end
            if (io_addr != 0)  mdat[io_addr] = io_dd_val;
            if (mem_addr != 0) mdat[mem_addr] = mem_dd_val;
            if (alu_addr != 0) mdat[alu_addr] = alu_dd_val;
        end
    endtask

    typedef struct {
        bit chk;
        bit r;
        int rs;
        bit iv;
        int dd;
        int aa, av, ma, mv, ia, iov;
        int e_val;
        bit e_pend, e_rdy, e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit c, input bit r, input int rs,
                       input bit iv, input int dd,
                       input int aa, input int av, input int ma,
                       input int mv, input int ia, input int iov,
                       input int ev, input bit ep, input bit er,
                       input bit ee);
        vec_t v;
        v.chk = c; v.r = r; v.rs = rs; v.iv = iv; v.dd = dd;
        v.aa = aa; v.av = av; v.ma = ma; v.mv = mv; v.ia = ia;
        v.iov = iov; v.e_val = ev; v.e_pend = ep; v.e_rdy = er;
        v.e_err = ee;
        tbl.push_back(v);
    endtask

    initial begin
        rstn = 1'b0; rs_addr = '0; rt_addr = '0; iss_vld = 1'b0;
        iss_dd = '0; alu_addr = '0; mem_addr = '0; io_addr = '0;
        alu_dd_val = '0; mem_dd_val = '0; io_dd_val = '0;

        //   chk r  rs iv dd aa av      ma mv    ia iov    val  pend rdy err
        add(0, 0, 0, 0, 0, 0, 0,      0, 0,    0, 0,     0, 0, 1, 0);
        add(1, 1, 5, 0, 0, 0, 0,      0, 0,    0, 0,     0, 0, 1, 0);
        add(1, 1, 3, 1, 3, 0, 0,      0, 0,    0, 0,     0, 0, 1, 0);
        add(1, 1, 3, 0, 0, 0, 0,      0, 0,    0, 0,     0, 1, 1, 0);
        add(1, 1, 3, 0, 0, 3, 'h1234, 0, 0,    0, 0,
            BYP ? 'h1234 : 0, !BYP, 1, 0);
        add(1, 1, 3, 0, 0, 0, 0,      0, 0,    0, 0,     'h1234, 0, 1, 0);
        add(1, 1, 7, 1, 7, 0, 0,      0, 0,    0, 0,     0, 0, 1, 0);
        add(1, 1, 7, 1, 7, 0, 0,      0, 0,    0, 0,     0, 1, 1, 0);
        add(1, 1, 7, 1, 7, 0, 0,      0, 0,    0, 0,     0, 1, 1, 0);
        add(1, 1, 7, 1, 7, 0, 0,      0, 0,    0, 0,     0, 1, 0, 0);
        add(1, 1, 7, 1, 7, 0, 0,      7, 'h55, 0, 0,
            BYP ? 'h55 : 0, 1, 0, 0);
        add(1, 1, 7, 1, 7, 0, 0,      0, 0,    0, 0,     'h55, 1, 1, 0);
        add(1, 1, 7, 0, 0, 7, 'h66,   7, 'h77, 7, 'h88,
            BYP ? 'h66 : 'h55, !BYP, 1, 0);
        add(1, 1, 7, 0, 0, 0, 0,      0, 0,    0, 0,     'h66, 0, 1, 0);
        add(1, 1, 9, 1, 9, 0, 0,      0, 0,    0, 0,     0, 0, 1, 0);
        add(1, 1, 9, 1, 9, 0, 0,      0, 0,    0, 0,     0, 1, 1, 0);
        add(1, 1, 9, 1, 9, 0, 0,      0, 0,    0, 0,     0, 1, 1, 0);
        add(1, 1, 9, 0, 0, 9, 1,      9, 2,    9, 3,
            BYP ? 1 : 0, !BYP, 1, 0);
        add(1, 1, 9, 0, 0, 0, 0,      0, 0,    0, 0,     1, 0, 1, 0);
        add(1, 1, 12, 0, 0, 0, 0,     0, 0,    12, 'hABC,
            BYP ? 'hABC : 0, 0, 1, 0);
        add(1, 1, 12, 0, 0, 0, 0,     0, 0,    0, 0,     'hABC, 0, 1, 1);
        add(1, 1, 0, 1, 0, 0, 0,      0, 0,    0, 0,     0, 0, 1, 1);
        add(1, 1, 0, 1, 4, 0, 0,      0, 0,    0, 0,     0, 0, 1, 1);
        add(1, 0, 4, 0, 0, 4, 'h99,   0, 0,    0, 0,
            BYP ? 'h99 : 0, !BYP, 1, 1);
        add(1, 1, 4, 0, 0, 0, 0,      0, 0,    0, 0,     0, 0, 1, 0);
        add(1, 1, 12, 0, 0, 0, 0,     0, 0,    0, 0,     0, 0, 1, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].rs, 0, tbl[i].iv, tbl[i].dd,
                  tbl[i].aa, tbl[i].av, tbl[i].ma, tbl[i].mv,
                  tbl[i].ia, tbl[i].iov);
            if (tbl[i].chk) begin
                chk($sformatf("v%0d_rs_val", i), rs_val, tbl[i].e_val);
                chk($sformatf("v%0d_rs_pend", i), {31'd0, rs_pend},
                    {31'd0, tbl[i].e_pend});
                chk($sformatf("v%0d_iss_rdy", i), {31'd0, iss_rdy},
                    {31'd0, tbl[i].e_rdy});
                chk($sformatf("v%0d_wb_err", i), {31'd0, wb_err},
                    {31'd0, tbl[i].e_err});
            end
            commit();
        end

        // Random traffic on a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            int w [3];
            for (int k = 0; k < 3; k++) begin
                int r;
                r = $urandom_range(1, 15);
                if ($urandom_range(0, 9) == 0)
                    w[k] = r;
                else if ($urandom_range(0, 1) == 0 && mcnt[r] > 0)
                    w[k] = r;
                else
                    w[k] = 0;
            end
            drive($urandom_range(0, 149) != 0,
                  $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                  w[0], $urandom, w[1], $urandom, w[2], $urandom);
            commit();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Integer register file and writeback scoreboard directly downstream of the execution unit.
- Accepts the three writeback streams (ALU, MEM, IO) and commits them to a 64x32 register array.
- Tracks outstanding writes per register so issue logic can stall on hazards.
- Supplies the ds/dt operand values that feed the execution unit.

Parameters:
NREG, 64, number of architectural registers (address width log2(NREG))
AW, 6, register address width
DW, 32, data width
CW, 2, width of per-register outstanding-write counter

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
rs_addr  in  AW  read port A address
rt_addr  in  AW  read port B address
rs_val  out  DW  read port A data (combinational)
rt_val  out  DW  read port B data (combinational)
rs_pend  out  1  register rs_addr has an outstanding write not yet satisfied
rt_pend  out  1  same for rt_addr
iss_vld  in  1  issue of an instruction writing iss_dd
iss_dd  in  AW  destination of the issuing instruction
iss_rdy  out  1  issue accepted this cycle (counter not saturated)
alu_addr  in  AW  ALU writeback address, 0 = none
alu_dd_val  in  DW  ALU writeback data
mem_addr  in  AW  MEM writeback address, 0 = none
mem_dd_val  in  DW  MEM writeback data
io_addr  in  AW  IO writeback address, 0 = none
io_dd_val  in  DW  IO writeback data
wb_err  out  1  sticky: writeback arrived for a register with zero outstanding count

Behaviour:
- Reset (rstn=0 at posedge): all array entries 0, all counters 0, wb_err 0. Reset mid-operation drops all pending state; writebacks in that cycle are discarded.
- Register 0: reads 0, never written, never pending. Issue with iss_dd=0 is a no-op; iss_rdy=1.
- Write commit: at posedge, each port with addr!=0 writes its data.
  - Two or more ports targeting the same address in one cycle: data priority ALU > MEM > IO.
  - The counter still decrements once per matching port.
- Counter update per register r, at posedge:
  - inc = iss_vld & iss_rdy & (iss_dd==r).
  - dec = number of writeback ports with addr==r.
  - next = cnt + inc - dec.
  - If dec > cnt + inc: next = 0 and wb_err sets (sticky until reset).
- iss_rdy = (iss_dd==0) | (cnt[iss_dd] != 2^CW-1). Combinational; a same-cycle writeback does not raise iss_rdy.
- Reads: rs_val = array[rs_addr] (0 if rs_addr==0); rs_pend = cnt[rs_addr]!=0. Same for rt. A same-cycle issue does not affect pend until the next cycle.
- Counter wrap is impossible: saturation is blocked by iss_rdy.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined:
  - rs_val/rt_val forward same-cycle writeback data (ALU > MEM > IO priority) when a port addr matches the read address (nonzero).
  - rs_pend/rt_pend are computed from the counter after this cycle's decrements, so a read of a register whose last outstanding write lands this cycle is not pending.
- Undefined: reads see only the array; data and pend clear one cycle after the writeback edge.

Test Plan:
- Reset, then read rs_addr=5 -> rs_val=0, rs_pend=0, wb_err=0.
- Issue dd=3, next cycle rs_addr=3 -> rs_pend=1. alu_addr=3, val=0x1234 one cycle later.
  - With RF_BYPASS_EN: rs_val=0x1234, rs_pend=0 in the writeback cycle.
  - Without: both update next cycle.
- Issue dd=7 three times (CW=2) -> iss_rdy=0 on the fourth attempt, counter holds 3. One mem writeback to 7 -> iss_rdy=1 next cycle.
- Same-cycle alu_addr=mem_addr=io_addr=9 with vals 1/2/3 after three issues to 9 -> array[9]=1, counter 0, rs_pend(9)=0.
- io_addr=12 with no prior issue -> wb_err=1 and stays 1; array[12] written.
- iss_dd=0 with alu_addr=0 -> no state change, rs_val(0)=0, iss_rdy=1.
